// File: rtl/ysyx_24080014_fetch_seq.sv
// Multi-cycle instruction sequencer for the NPC core.
// Walks each instruction through IDLE -> FETCH -> WAIT_R -> EXEC -> COMMIT,
// drives the instruction-memory read handshake from the current PC, hands the
// fetched word to execute, and produces the one-cycle PC load with the
// selected next PC. At most one fetch is outstanding; there is no prefetch.
module ysyx_24080014_fetch_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            imem_arvalid,
  output logic [XLEN-1:0] imem_araddr,
  input  logic            imem_arready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic [1:0]      imem_rresp,
  output logic            imem_rready,
  output logic [31:0]     inst_o,
  output logic            inst_valid,
  input  logic            exu_done,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_req,
  input  logic            mret,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            pc_we,
  output logic [XLEN-1:0] next_pc,
  output logic            fault_o,
  output logic [63:0]     instret
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_R,
    S_EXEC,
    S_COMMIT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] exec_next_pc;

  // The PC register only changes at the end of COMMIT, so pc_i is already
  // stable for the whole FETCH phase and can drive the address directly.
  assign imem_araddr = pc_i;

  // Next-PC selection for a completed (non-faulting) instruction; the
  // redirect inputs are only meaningful while exu_done is high.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    exec_next_pc = pc_i + XLEN'(4);
    if (trap_req)      exec_next_pc = mtvec;
    else if (mret)     exec_next_pc = mepc;
    else if (br_taken) exec_next_pc = br_target;
  end

  // Sequencer FSM with all handshake and commit outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state        <= S_IDLE;
      imem_arvalid <= 1'b0;
      imem_rready  <= 1'b0;
      inst_o       <= '0;
      inst_valid   <= 1'b0;
      pc_we        <= 1'b0;
      next_pc      <= RESET_PC;
      fault_o      <= 1'b0;
      instret      <= '0;
    end else begin
      // Pulse outputs fall back to zero unless the transition below sets them.
      inst_valid <= 1'b0;
      pc_we      <= 1'b0;
      fault_o    <= 1'b0;

      unique case (state)
        S_IDLE: begin
          imem_arvalid <= 1'b1;
          state        <= S_FETCH;
        end

        S_FETCH: begin
          if (imem_arready) begin
            imem_arvalid <= 1'b0;
            imem_rready  <= 1'b1;
            state        <= S_WAIT_R;
          end
        end

        S_WAIT_R: begin
          if (imem_rvalid) begin
            imem_rready <= 1'b0;
            inst_o      <= imem_rdata;
            if (imem_rresp == 2'b00) begin
              inst_valid <= 1'b1;
              state      <= S_EXEC;
            end else begin
              // Access fault: skip execute and vector straight to the handler.
              pc_we   <= 1'b1;
              fault_o <= 1'b1;
              next_pc <= mtvec;
              state   <= S_COMMIT;
            end
          end
        end

        S_EXEC: begin
          if (exu_done) begin
            pc_we   <= 1'b1;
            next_pc <= exec_next_pc;
            state   <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          // fault_o is still high here exactly when this commit is a fault.
          if (!fault_o) instret <= instret + 64'd1;
          imem_arvalid <= 1'b1;
          state        <= S_FETCH;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_fetch_seq.sv
// Directed bench for ysyx_24080014_fetch_seq: a table of instructions with
// memory latencies, execute redirects and hand-computed next PCs, plus a
// reset-in-flight sequence and the PC wrap-around case.
module tb_ysyx_24080014_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        exu_done;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap_req;
  logic        mret;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        pc_we;
  logic [31:0] next_pc;
  logic        fault_o;
  logic [63:0] instret;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_instret;

  ysyx_24080014_fetch_seq dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .imem_arvalid (imem_arvalid),
    .imem_araddr  (imem_araddr),
    .imem_arready (imem_arready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .imem_rresp   (imem_rresp),
    .imem_rready  (imem_rready),
    .inst_o       (inst_o),
    .inst_valid   (inst_valid),
    .exu_done     (exu_done),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .trap_req     (trap_req),
    .mret         (mret),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .pc_we        (pc_we),
    .next_pc      (next_pc),
    .fault_o      (fault_o),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        br;
    logic [31:0] br_target;
    logic        trap;
    logic [31:0] mtvec;
    logic        mret;
    logic [31:0] mepc;
    int          ar_dly;
    int          r_dly;
    int          ex_dly;
    logic [31:0] exp_next;
    logic        exp_fault;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic [31:0] pc, input logic [31:0] rdata, input logic [1:0] rresp,
    input logic br, input logic [31:0] bt, input logic trap, input logic [31:0] tv,
    input logic mr, input logic [31:0] ep, input int ad, input int rd, input int ed,
    input logic [31:0] exp_next, input logic exp_fault);
    vec_t v;
    v.pc = pc;  v.rdata = rdata;  v.rresp = rresp;
    v.br = br;  v.br_target = bt; v.trap = trap; v.mtvec = tv;
    v.mret = mr; v.mepc = ep;
    v.ar_dly = ad; v.r_dly = rd; v.ex_dly = ed;
    v.exp_next = exp_next; v.exp_fault = exp_fault;
    return v;
  endfunction

  // Redirect inputs are don't-care outside the exu_done cycle; drive values
  // that would corrupt next_pc if the sequencer ever sampled them.
  task automatic drive_noise();
    br_taken  = 1'b1;
    br_target = 32'h1234_5670;
    trap_req  = 1'b1;
    mret      = 1'b1;
    mtvec     = 32'hBAD0_0000;
    mepc      = 32'hBAD0_0004;
  endtask

  // Runs one instruction from FETCH through the cycle after COMMIT.
  // Entered and left on a falling edge; exp_wait is the number of cycles
  // before arvalid is expected to appear.
  task automatic run_instr(input vec_t v, input int exp_wait);
    int waited = 0;
    pc_i = v.pc;
    while (!imem_arvalid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!imem_arvalid) begin
      check("arvalid_timeout", {63'd0, imem_arvalid}, 64'd1);
      return;
    end
    check("fetch_start_wait", 64'(waited), 64'(exp_wait));

    // FETCH: request held until accepted, no rready.
    for (int k = 0; k <= v.ar_dly; k++) begin
      check("fetch_hold", {30'd0, imem_arvalid, imem_rready, imem_araddr},
            {30'd0, 1'b1, 1'b0, v.pc});
      if (k == v.ar_dly) imem_arready = 1'b1;
      @(negedge clk);
    end
    imem_arready = 1'b0;

    // WAIT_R: rready only here, request dropped.
    for (int k = 0; k <= v.r_dly; k++) begin
      check("wait_r_hs", {61'd0, imem_arvalid, imem_rready, inst_valid}, {61'd0, 3'b010});
      if (k == v.r_dly) begin
        imem_rvalid = 1'b1;
        imem_rdata  = v.rdata;
        imem_rresp  = v.rresp;
        mtvec       = v.mtvec;
      end
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hFFFF_FFFF;
    imem_rresp  = 2'b11;

    if (!v.exp_fault) begin
      // EXEC: single inst_valid pulse on the first cycle.
      check("inst_valid_pulse", {63'd0, inst_valid}, 64'd1);
      check("inst_latched", {32'd0, inst_o}, {32'd0, v.rdata});
      for (int k = 0; k <= v.ex_dly; k++) begin
        if (k > 0) check("exec_wait", {62'd0, inst_valid, pc_we}, 64'd0);
        if (k == v.ex_dly) begin
          exu_done  = 1'b1;
          br_taken  = v.br;
          br_target = v.br_target;
          trap_req  = v.trap;
          mtvec     = v.mtvec;
          mret      = v.mret;
          mepc      = v.mepc;
        end else begin
          exu_done = 1'b0;
          drive_noise();
        end
        @(negedge clk);
      end
      exu_done = 1'b0;
      drive_noise();
    end else begin
      drive_noise();
    end

    // COMMIT: one pc_we pulse with the selected next PC.
    check("commit_flags", {61'd0, pc_we, fault_o, inst_valid},
          {61'd0, 1'b1, v.exp_fault, 1'b0});
    check("commit_next_pc", {32'd0, next_pc}, {32'd0, v.exp_next});
    if (v.exp_fault) check("fault_inst_o", {32'd0, inst_o}, {32'd0, v.rdata});
    pc_i = v.exp_next;
    if (!v.exp_fault) exp_instret = exp_instret + 64'd1;
    @(negedge clk);

    // Back in FETCH: pulses gone, next_pc held, counter updated.
    check("post_commit_flags", {61'd0, pc_we, fault_o, imem_arvalid}, 64'd1);
    check("post_commit_next_pc", {32'd0, next_pc}, {32'd0, v.exp_next});
    check("instret", instret, exp_instret);
  endtask

  vec_t vecs[9];

  initial begin
    // pc, rdata, rresp, br, br_target, trap, mtvec, mret, mepc, ar, r, ex, next, fault
    vecs[0] = mk(32'h8000_0000, 32'h0000_0013, 2'b00, 1'b0, 32'h0, 1'b0, 32'h8000_0800,
                 1'b0, 32'h8000_0040, 0, 0, 0, 32'h8000_0004, 1'b0);
    vecs[1] = mk(32'h8000_0004, 32'h0000_0063, 2'b00, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0800,
                 1'b0, 32'h8000_0040, 0, 0, 0, 32'h8000_0100, 1'b0);
    vecs[2] = mk(32'h8000_0100, 32'h0000_0093, 2'b00, 1'b0, 32'h0, 1'b0, 32'h8000_0800,
                 1'b0, 32'h8000_0040, 3, 2, 0, 32'h8000_0104, 1'b0);
    vecs[3] = mk(32'h8000_0104, 32'h0000_0073, 2'b00, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0800,
                 1'b0, 32'h8000_0040, 0, 0, 1, 32'h8000_0800, 1'b0);
    vecs[4] = mk(32'h8000_0800, 32'h3020_0073, 2'b00, 1'b0, 32'h0, 1'b0, 32'h8000_0800,
                 1'b1, 32'h8000_0040, 0, 1, 2, 32'h8000_0040, 1'b0);
    vecs[5] = mk(32'h8000_0040, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0800,
                 1'b0, 32'h8000_0040, 0, 0, 0, 32'h8000_0800, 1'b1);
    vecs[6] = mk(32'h8000_0800, 32'h0000_0000, 2'b01, 1'b0, 32'h0, 1'b0, 32'h8000_0C00,
                 1'b0, 32'h8000_0040, 1, 0, 0, 32'h8000_0C00, 1'b1);
    vecs[7] = mk(32'h8000_0C00, 32'h0000_0073, 2'b00, 1'b0, 32'h0, 1'b1, 32'h8000_0900,
                 1'b1, 32'h8000_0044, 0, 0, 0, 32'h8000_0900, 1'b0);
    vecs[8] = mk(32'h8000_0900, 32'h3020_0073, 2'b00, 1'b1, 32'h8000_0200, 1'b0, 32'h8000_0900,
                 1'b1, 32'h8000_0044, 0, 0, 1, 32'h8000_0044, 1'b0);

    rst          = 1'b0;
    pc_i         = 32'h8000_0000;
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    imem_rresp   = 2'b00;
    exu_done     = 1'b0;
    drive_noise();
    exp_instret  = 64'd0;

    repeat (3) @(negedge clk);
    check("reset_handshake", {61'd0, imem_arvalid, imem_rready, inst_valid}, 64'd0);
    check("reset_commit", {62'd0, pc_we, fault_o}, 64'd0);
    check("reset_next_pc", {32'd0, next_pc}, 64'h8000_0000);
    check("reset_inst_o", {32'd0, inst_o}, 64'd0);
    check("reset_instret", instret, 64'd0);

    // Release reset: IDLE for one cycle, then FETCH.
    rst = 1'b1;
    for (int i = 0; i < 9; i++) run_instr(vecs[i], (i == 0) ? 1 : 0);

    // Reset while waiting for read data, followed by a stray rvalid.
    imem_arready = 1'b1;
    @(negedge clk);
    imem_arready = 1'b0;
    check("pre_abort_wait_r", {62'd0, imem_rready, imem_arvalid}, 64'd2);
    rst = 1'b0;
    @(negedge clk);
    check("abort_handshake", {61'd0, imem_arvalid, imem_rready, inst_valid}, 64'd0);
    check("abort_next_pc", {32'd0, next_pc}, 64'h8000_0000);
    check("abort_instret", instret, 64'd0);
    check("abort_pc_we", {63'd0, pc_we}, 64'd0);
    exp_instret = 64'd0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    imem_rresp  = 2'b00;
    pc_i        = 32'hFFFF_FFFC;
    rst         = 1'b1;
    @(negedge clk);
    check("late_rvalid_idle", {61'd0, inst_valid, imem_rready, imem_arvalid}, 64'd1);
    @(negedge clk);
    check("late_rvalid_fetch", {61'd0, inst_valid, imem_rready, imem_arvalid}, 64'd1);
    check("late_rvalid_inst_o", {32'd0, inst_o}, 64'd0);
    imem_rvalid = 1'b0;

    // Sequential commit from the top of the address space wraps to zero.
    run_instr(mk(32'hFFFF_FFFC, 32'h0000_0013, 2'b00, 1'b0, 32'h0, 1'b0, 32'h8000_0800,
                 1'b0, 32'h8000_0040, 0, 0, 0, 32'h0000_0000, 1'b0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
